// File: rtl/defines_pkg.sv
// Shared types for the even-pipe issue controller: opcode set, latency classes, stage entry.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package defines_pkg;

    localparam int EP_NUM_STAGES  = 7;
    localparam int EP_REG_ADDR_WD = 7;

    // Latency class: the stage from which a result may first be forwarded.
    typedef logic [2:0] ep_lat_t;

    // Forward-select encoding for "read from the register file".
    localparam ep_lat_t FWD_RF = 3'd0;

    typedef enum logic [4:0] {
        IMMEDIATE_LOAD_HALFWORD,
        IMMEDIATE_LOAD_WORD,
        IMMEDIATE_LOAD_ADDRESS,
        ADD_WORD,
        SUBTRACT_FROM_WORD,
        AND_WORD,
        OR_WORD,
        COMPARE_EQUAL_WORD,
        SHIFT_LEFT_HALFWORD_IMMEDIATE,
        SHIFT_LEFT_WORD,
        ROTATE_WORD,
        COUNT_ONES_IN_BYTES,
        AVERAGE_BYTES,
        FLOATING_ADD,
        FLOATING_MULTIPLY,
        FLOATING_MULTIPLY_AND_ADD,
        MULTIPLY,
        MULTIPLY_UNSIGNED,
        STOP_AND_SIGNAL
    } Opcodes;

    // One in-flight entry per pipe stage.
    typedef struct packed {
        logic                      vld;
        logic                      wr;
        logic [EP_REG_ADDR_WD-1:0] rt_addr;
        ep_lat_t                   lat;
    } ep_stage_t;

    function automatic ep_lat_t ep_latency(input Opcodes op);
        case (op)
            IMMEDIATE_LOAD_HALFWORD, IMMEDIATE_LOAD_WORD, IMMEDIATE_LOAD_ADDRESS,
            ADD_WORD, SUBTRACT_FROM_WORD, AND_WORD, OR_WORD, COMPARE_EQUAL_WORD:
                return 3'd2;
            SHIFT_LEFT_HALFWORD_IMMEDIATE, SHIFT_LEFT_WORD, ROTATE_WORD,
            COUNT_ONES_IN_BYTES, AVERAGE_BYTES:
                return 3'd4;
            FLOATING_ADD, FLOATING_MULTIPLY, FLOATING_MULTIPLY_AND_ADD:
                return 3'd6;
            MULTIPLY, MULTIPLY_UNSIGNED:
                return 3'd7;
            // Anything not classified is treated as the slowest unit.
            default:
                return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/ep_hazard_check.sv
// RAW hazard check for one source operand: youngest in-flight writer decides ready / forward stage.
// Latency: purely combinational.
// Backpressure: ready_o low stalls issue; EP_FWD_EN selects bypass forwarding, otherwise wait for retire.
//
// Ports: src_used_i/src_addr_i describe the operand, stages_i is the stage array
// (index 0 = stage 1), ready_o / fwd_sel_o are the verdict for this operand.
module ep_hazard_check
    import defines_pkg::*;
#(
    parameter int NUM_STAGES = EP_NUM_STAGES,
    parameter int ADDR_WD    = EP_REG_ADDR_WD
) (
    input  logic                        src_used_i,
    input  logic [ADDR_WD-1:0]          src_addr_i,
    input  ep_stage_t [NUM_STAGES-1:0]  stages_i,
    output logic                        ready_o,
    output logic [2:0]                  fwd_sel_o
);

    logic found;

    // Scan from the youngest stage; the first hit shadows every older one,
    // so a not-ready young producer stalls even if an older one is ready.
    always_comb begin
        ready_o   = 1'b1;
        fwd_sel_o = FWD_RF;
        found     = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (src_used_i && !found && stages_i[i].vld && stages_i[i].wr &&
                (stages_i[i].rt_addr == src_addr_i)) begin
                found = 1'b1;
`ifdef EP_FWD_EN
                if (ep_lat_t'(i + 1) < stages_i[i].lat) begin
                    ready_o = 1'b0;
                end else begin
                    fwd_sel_o = ep_lat_t'(i + 1);
                end
`else
                // No bypass: any in-flight writer blocks until it has retired.
                ready_o = 1'b0;
`endif
            end
        end
    end

`ifndef EP_FWD_EN
    // Latency classes only matter when forwarding is built in.
    logic lat_unused;
    always_comb begin
        lat_unused = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            lat_unused = lat_unused ^ (^stages_i[i].lat);
        end
    end
`endif

endmodule

// File: rtl/ep_issue_ctrl.sv
// Even-pipe issue controller/scoreboard: RAW stall, bypass selects, stage-7 writeback.
// Latency: issue is combinational; writeback strobes 7 cycles after issue.
// Backpressure: in_ready drops on flush, reset or an unready used source (EP_FWD_EN enables bypass).
//
// Ports: clk/rst (async, active-low); in_* decoded instruction with valid/ready;
// flush discards in-flight work; ep_issue/ep_opcode/ep_rt_addr feed even_pipe;
// fwd_sel_ra/rb/rc pick RF (0) or rf_data_sK_ep (2..7); wb_en/wb_addr write the RF;
// busy flags any valid in-flight entry.
module ep_issue_ctrl
    import defines_pkg::*;
#(
    parameter int REG_ADDR_WD = EP_REG_ADDR_WD,
    parameter int NUM_STAGES  = EP_NUM_STAGES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  Opcodes                 in_opcode,
    input  logic [REG_ADDR_WD-1:0] in_ra_addr,
    input  logic [REG_ADDR_WD-1:0] in_rb_addr,
    input  logic [REG_ADDR_WD-1:0] in_rc_addr,
    input  logic [2:0]             in_src_used,
    input  logic [REG_ADDR_WD-1:0] in_rt_addr,
    input  logic                   in_rt_wr,
    input  logic                   flush,
    output logic                   ep_issue,
    output Opcodes                 ep_opcode,
    output logic [REG_ADDR_WD-1:0] ep_rt_addr,
    output logic [2:0]             fwd_sel_ra,
    output logic [2:0]             fwd_sel_rb,
    output logic [2:0]             fwd_sel_rc,
    output logic                   wb_en,
    output logic [REG_ADDR_WD-1:0] wb_addr,
    output logic                   busy
);

    ep_stage_t [NUM_STAGES-1:0] stage_q, stage_d;
    logic rdy_ra, rdy_rb, rdy_rc;

    ep_hazard_check #(.NUM_STAGES(NUM_STAGES), .ADDR_WD(REG_ADDR_WD)) u_hz_ra (
        .src_used_i (in_src_used[0]),
        .src_addr_i (in_ra_addr),
        .stages_i   (stage_q),
        .ready_o    (rdy_ra),
        .fwd_sel_o  (fwd_sel_ra)
    );

    ep_hazard_check #(.NUM_STAGES(NUM_STAGES), .ADDR_WD(REG_ADDR_WD)) u_hz_rb (
        .src_used_i (in_src_used[1]),
        .src_addr_i (in_rb_addr),
        .stages_i   (stage_q),
        .ready_o    (rdy_rb),
        .fwd_sel_o  (fwd_sel_rb)
    );

    ep_hazard_check #(.NUM_STAGES(NUM_STAGES), .ADDR_WD(REG_ADDR_WD)) u_hz_rc (
        .src_used_i (in_src_used[2]),
        .src_addr_i (in_rc_addr),
        .stages_i   (stage_q),
        .ready_o    (rdy_rc),
        .fwd_sel_o  (fwd_sel_rc)
    );

    // rst is folded in so nothing is accepted while the pipe is held in reset.
    assign in_ready   = rst && !flush && rdy_ra && rdy_rb && rdy_rc;
    assign ep_issue   = in_valid && in_ready;
    assign ep_opcode  = in_opcode;
    assign ep_rt_addr = in_rt_addr;

    // Unconditional shift; stage 1 is loaded only by an issue.
    always_comb begin
        stage_d = '0;
        if (ep_issue) begin
            stage_d[0].vld     = 1'b1;
            stage_d[0].wr      = in_rt_wr;
            stage_d[0].rt_addr = in_rt_addr;
            stage_d[0].lat     = ep_latency(in_opcode);
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_d[i].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Writeback comes straight from the last stage register, so a flush in
    // the same cycle does not suppress it.
    assign wb_en   = stage_q[NUM_STAGES-1].vld && stage_q[NUM_STAGES-1].wr;
    assign wb_addr = stage_q[NUM_STAGES-1].rt_addr;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            busy = busy | stage_q[i].vld;
        end
    end

endmodule

// File: doc/ep_issue_ctrl.md
# ep_issue_ctrl

Issue controller and scoreboard for the SPU-Lite even pipe. It accepts decoded even-pipe instructions over a valid/ready handshake and tracks each in-flight destination through stages 1..7. It stalls on read-after-write hazards, drives per-operand forwarding selects for the `rf_addr_s2_ep..s7_ep` / `rf_data_s2_ep..s7_ep` bypass network, and generates register-file writeback at stage 7. It sits between the decode/dual-issue logic and `even_pipe`.

## Interface
- `REG_ADDR_WD`, 7: register address width.
- `NUM_STAGES`, 7: pipe depth; writeback occurs from stage `NUM_STAGES`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: instruction accepted this cycle when `in_valid` is also high.
- `in_opcode` in `Opcodes`: even-pipe opcode.
- `in_ra_addr`, `in_rb_addr`, `in_rc_addr` in 7 each: source register addresses.
- `in_src_used` in 3: bit0 RA, bit1 RB, bit2 RC; an unused source never causes a hazard.
- `in_rt_addr` in 7: destination register.
- `in_rt_wr` in 1: instruction writes RT.
- `flush` in 1: discard all in-flight instructions.
- `ep_issue` out 1: instruction issued to `even_pipe`; equals `in_valid && in_ready`.
- `ep_opcode` out `Opcodes`: opcode passed through to `even_pipe`.
- `ep_rt_addr` out 7: destination passed through to `even_pipe`.
- `fwd_sel_ra`, `fwd_sel_rb`, `fwd_sel_rc` out 3: operand source. 0 selects the register file; 2..7 selects `rf_data_sK_ep`.
- `wb_en` out 1: register-file write strobe.
- `wb_addr` out 7: register-file write address.
- `busy` out 1: at least one valid in-flight entry.

## Operation
- Each stage register holds {valid, wr, rt_addr, lat}. An issue loads stage 1; all entries shift one stage per cycle unconditionally; the stage-7 entry retires.
- Latency classes come from `ep_latency(opcode)`:
  - 2: IMMEDIATE_LOAD_HALFWORD, IMMEDIATE_LOAD_WORD, IMMEDIATE_LOAD_ADDRESS, simple fixed-point.
  - 4: shift/rotate (including SHIFT_LEFT_HALFWORD_IMMEDIATE), byte ops.
  - 6: single-precision float.
  - 7: float/integer multiply.
  - Any unlisted opcode defaults to 7.
- Hazard check runs per used source against every valid entry with `wr=1` and `rt_addr` equal to the source address.
  - Only the youngest match (lowest stage k) counts.
  - If k < lat, the source is not ready: `in_ready=0`.
  - If k >= lat, set `fwd_sel=k`.
  - If no entry matches, set `fwd_sel=0`.
  - When the youngest match is not ready, stall even if an older match is ready.
- `in_ready = !flush && all used sources ready`. While `in_valid=0`, `in_ready` reflects the hazard state of the presented fields, and `fwd_sel` is don't-care.
- `wb_en` = stage-7 valid && wr; `wb_addr` = stage-7 rt_addr. A consumer issued in the same cycle as a stage-7 writeback forwards from stage 7, because the register-file write is not visible until the next cycle.
- Instructions with `in_rt_wr=0` occupy a stage slot but create no hazard and no writeback.
- No write-after-write hazard handling is needed: writeback is always in order at stage 7.
- `flush`:
  - Clears all valid bits at the next edge.
  - `in_ready=0` in the flush cycle.
  - `wb_en` for the stage-7 entry in the flush cycle still asserts.
- Reset:
  - Asynchronously clears all stage valid bits.
  - `wb_en=0`, `wb_addr=0`, `busy=0`.
  - `ep_issue=0` and `in_ready=0` while `rst` is low.
  - In-flight instructions are lost.

## Timing
- Issue in cycle T; the entry is at stage k in cycle T+k; `wb_en` asserts in cycle T+7.
- The earliest dependent issue is T+lat, with `fwd_sel=lat`.
- `in_ready`, `ep_issue` and `fwd_sel_*` are combinational from the inputs and stage registers. `wb_en`, `wb_addr` and `busy` are combinational from registers only.
- Throughput is one issue per cycle when there is no hazard.

## Configuration
- `EP_FWD_EN` defined: forwarding behaves as described above.
- `EP_FWD_EN` undefined:
  - `fwd_sel_*` is tied to 0.
  - A source is ready only when no valid in-flight entry writes its address, so the consumer waits until the producer has retired.
  - Earliest dependent issue becomes T+8 regardless of latency class.

## Structure
- `defines_pkg` holds:
  - `ep_lat_t` and the function `ep_latency(Opcodes)`;
  - `EP_NUM_STAGES`;
  - `FWD_RF = 3'd0`;
  - the `ep_stage_t` struct.
- One sub-module, `ep_hazard_check`: combinational youngest-match search plus ready/`fwd_sel` generation for a single source. It is instantiated three times (RA, RB, RC).

## Test plan
- Eight back-to-back ILH issues to $1..$8 with no dependencies -> `in_ready=1` throughout; `wb_en` at T+7..T+14 with `wb_addr` 1..8.
- ILH $10 at T, then an instruction reading RA=$10 -> `in_ready=0` at T+1; issues at T+2 with `fwd_sel_ra=2`.
- Float op $20 (lat 6) at T, then a reader of $20 -> stalled T+1..T+5; issues at T+6 with `fwd_sel_ra=6`.
- Float writes $5 at T, ILH writes $5 at T+1, reader of $5 -> stall at T+2; issues at T+3 with `fwd_sel_ra=2`, ignoring the older not-ready entry.
- Three instructions in flight, then `rst` low mid-cycle -> `busy=0` and `wb_en=0` immediately, and no writeback after release. Separately, `flush` with two in flight -> no later `wb_en`, and `in_ready=0` in the flush cycle.
- `EP_FWD_EN` undefined, repeat the ILH $10 dependency scenario -> the reader issues at T+8 with `fwd_sel_ra=0`.
